// File: rtl/ipgen_slave_lite_arbiter2.sv
// ---------------------------------------------------------------------------
// ipgen_slave_lite_arbiter2
//   Shares a single AXI4-Lite-style slave register port (AW/W/AR/R, no B
//   channel) between two requesters. One transaction is in flight at a time.
//   Simultaneous requests are resolved round-robin. A requester's write wins
//   over its own read.
//
//   Timing: a request seen in IDLE is granted at the next edge (grant cycle:
//   rN_awready/rN_arready pulse, busy=1). s_awvalid/s_arvalid then rise one
//   cycle later (drive cycle). The W and R channels are combinational
//   pass-throughs for the granted requester only.
//
// Ports
//   CLK, RST_N                 clock, asynchronous active-low reset
//   rN_aw*/rN_w*/rN_ar*/rN_r*  requester N (N=0,1) lite channels
//   s_aw*/s_w*/s_ar*/s_r*      shared slave-side lite channels
//   grant                      index of the owning requester (valid when busy)
//   busy                       a transaction is in progress
//
// Configuration macro
//   IPGEN_ARB_FIXED_PRIO_EN    defined: requester 0 always wins simultaneous
//                              requests. Undefined (default): round-robin.
// ---------------------------------------------------------------------------
module ipgen_slave_lite_arbiter2 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    // requester 0
    input  logic                    r0_awvalid,
    input  logic [ADDR_WIDTH-1:0]   r0_awaddr,
    output logic                    r0_awready,
    input  logic [DATA_WIDTH-1:0]   r0_wdata,
    input  logic [DATA_WIDTH/8-1:0] r0_wstrb,
    input  logic                    r0_wvalid,
    output logic                    r0_wready,
    input  logic                    r0_arvalid,
    input  logic [ADDR_WIDTH-1:0]   r0_araddr,
    output logic                    r0_arready,
    output logic [DATA_WIDTH-1:0]   r0_rdata,
    output logic                    r0_rvalid,
    input  logic                    r0_rready,
    // requester 1
    input  logic                    r1_awvalid,
    input  logic [ADDR_WIDTH-1:0]   r1_awaddr,
    output logic                    r1_awready,
    input  logic [DATA_WIDTH-1:0]   r1_wdata,
    input  logic [DATA_WIDTH/8-1:0] r1_wstrb,
    input  logic                    r1_wvalid,
    output logic                    r1_wready,
    input  logic                    r1_arvalid,
    input  logic [ADDR_WIDTH-1:0]   r1_araddr,
    output logic                    r1_arready,
    output logic [DATA_WIDTH-1:0]   r1_rdata,
    output logic                    r1_rvalid,
    input  logic                    r1_rready,
    // slave side
    output logic                    s_awvalid,
    output logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                    s_awready,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    output logic [DATA_WIDTH/8-1:0] s_wstrb,
    output logic                    s_wvalid,
    input  logic                    s_wready,
    output logic                    s_arvalid,
    output logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_arready,
    input  logic [DATA_WIDTH-1:0]   s_rdata,
    input  logic                    s_rvalid,
    output logic                    s_rready,
    // status
    output logic                    grant,
    output logic                    busy
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t                state_q, state_d;
    logic                  prio_q, prio_d;
    logic                  grant_q, grant_d;
    logic                  busy_q, busy_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  ar_done_q, ar_done_d;
    logic [1:0]            awready_q, awready_d;
    logic [1:0]            arready_q, arready_d;
    logic                  s_awvalid_q, s_awvalid_d;
    logic                  s_arvalid_q, s_arvalid_d;
    logic [ADDR_WIDTH-1:0] s_awaddr_q, s_awaddr_d;
    logic [ADDR_WIDTH-1:0] s_araddr_q, s_araddr_d;

    logic                  req0, req1, win_id, win_wr;
    logic                  in_write, in_read;
    logic                  g_wvalid, g_rready, w_open;
    logic [DATA_WIDTH-1:0] g_wdata;
    logic [STRB_WIDTH-1:0] g_wstrb;
    logic                  aw_hs, w_hs, ar_hs, r_hs;

    assign req0 = r0_awvalid | r0_arvalid;
    assign req1 = r1_awvalid | r1_arvalid;

`ifdef IPGEN_ARB_FIXED_PRIO_EN
    assign win_id = ~req0;
`else
    assign win_id = (req0 & req1) ? prio_q : req1;
`endif
    assign win_wr = win_id ? r1_awvalid : r0_awvalid;

    assign in_write = (state_q == WRITE);
    assign in_read  = (state_q == READ);

    // Granted-requester view of the W and R channels
    assign g_wvalid = grant_q ? r1_wvalid : r0_wvalid;
    assign g_wdata  = grant_q ? r1_wdata  : r0_wdata;
    assign g_wstrb  = grant_q ? r1_wstrb  : r0_wstrb;
    assign g_rready = grant_q ? r1_rready : r0_rready;

    // The W path closes once its single beat has been taken
    assign w_open   = in_write & ~w_done_q;
    assign s_wvalid = w_open & g_wvalid;
    assign s_wdata  = in_write ? g_wdata : '0;
    assign s_wstrb  = in_write ? g_wstrb : '0;
    assign r0_wready = w_open & ~grant_q & s_wready;
    assign r1_wready = w_open &  grant_q & s_wready;

    assign s_rready  = in_read & g_rready;
    assign r0_rvalid = in_read & ~grant_q & s_rvalid;
    assign r1_rvalid = in_read &  grant_q & s_rvalid;
    assign r0_rdata  = (in_read & ~grant_q) ? s_rdata : '0;
    assign r1_rdata  = (in_read &  grant_q) ? s_rdata : '0;

    assign aw_hs = s_awvalid_q & s_awready;
    assign w_hs  = s_wvalid & s_wready;
    assign ar_hs = s_arvalid_q & s_arready;
    assign r_hs  = s_rvalid & s_rready;

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        ar_done_d   = ar_done_q;
        awready_d   = 2'b00;
        arready_d   = 2'b00;
        s_awvalid_d = s_awvalid_q;
        s_arvalid_d = s_arvalid_q;
        s_awaddr_d  = s_awaddr_q;
        s_araddr_d  = s_araddr_q;

        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    grant_d = win_id;
                    busy_d  = 1'b1;
                    if (win_wr) begin
                        state_d    = WRITE;
                        s_awaddr_d = win_id ? r1_awaddr : r0_awaddr;
                        awready_d  = win_id ? 2'b10 : 2'b01;
                    end else begin
                        state_d    = READ;
                        s_araddr_d = win_id ? r1_araddr : r0_araddr;
                        arready_d  = win_id ? 2'b10 : 2'b01;
                    end
                end
            end
            WRITE: begin
                // Address goes out on the cycle after the grant pulse
                if (|awready_q) s_awvalid_d = 1'b1;
                if (aw_hs) begin
                    s_awvalid_d = 1'b0;
                    aw_done_d   = 1'b1;
                end
                if (w_hs) w_done_d = 1'b1;
                if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    aw_done_d   = 1'b0;
                    w_done_d    = 1'b0;
                    s_awvalid_d = 1'b0;
`ifdef IPGEN_ARB_FIXED_PRIO_EN
                    prio_d      = 1'b0;
`else
                    prio_d      = ~grant_q;
`endif
                end
            end
            READ: begin
                if (|arready_q) s_arvalid_d = 1'b1;
                if (ar_hs) begin
                    s_arvalid_d = 1'b0;
                    ar_done_d   = 1'b1;
                end
                if ((ar_done_q | ar_hs) & r_hs) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    ar_done_d   = 1'b0;
                    s_arvalid_d = 1'b0;
`ifdef IPGEN_ARB_FIXED_PRIO_EN
                    prio_d      = 1'b0;
`else
                    prio_d      = ~grant_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            grant_q     <= 1'b0;
            busy_q      <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            ar_done_q   <= 1'b0;
            awready_q   <= 2'b00;
            arready_q   <= 2'b00;
            s_awvalid_q <= 1'b0;
            s_arvalid_q <= 1'b0;
            s_awaddr_q  <= '0;
            s_araddr_q  <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            ar_done_q   <= ar_done_d;
            awready_q   <= awready_d;
            arready_q   <= arready_d;
            s_awvalid_q <= s_awvalid_d;
            s_arvalid_q <= s_arvalid_d;
            s_awaddr_q  <= s_awaddr_d;
            s_araddr_q  <= s_araddr_d;
        end
    end

    assign r0_awready = awready_q[0];
    assign r1_awready = awready_q[1];
    assign r0_arready = arready_q[0];
    assign r1_arready = arready_q[1];
    assign s_awvalid  = s_awvalid_q;
    assign s_arvalid  = s_arvalid_q;
    assign s_awaddr   = s_awaddr_q;
    assign s_araddr   = s_araddr_q;
    assign grant      = grant_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ipgen_slave_lite_arbiter2.sv
// ---------------------------------------------------------------------------
// tb_ipgen_slave_lite_arbiter2
//   Directed bench: a table of single-requester transactions plus
//   hand-written sequences for contention, back-pressure, reset and
//   arbitration fairness.
// ---------------------------------------------------------------------------
module tb_ipgen_slave_lite_arbiter2;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int SW = DW / 8;

    logic CLK = 1'b0;
    logic RST_N;

    logic [1:0]         awvalid_v, wvalid_v, arvalid_v, rready_v;
    logic [1:0][AW-1:0] awaddr_v, araddr_v;
    logic [1:0][DW-1:0] wdata_v;
    logic [1:0][SW-1:0] wstrb_v;
    logic [1:0]         awready_v, wready_v, arready_v, rvalid_v;
    logic [1:0][DW-1:0] rdata_v;

    logic          s_awvalid, s_wvalid, s_arvalid, s_rready;
    logic [AW-1:0] s_awaddr, s_araddr;
    logic [DW-1:0] s_wdata;
    logic [SW-1:0] s_wstrb;
    logic          s_awready, s_wready, s_arready, s_rvalid;
    logic [DW-1:0] s_rdata;
    logic          grant, busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 CLK = ~CLK;

    ipgen_slave_lite_arbiter2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .r0_awvalid(awvalid_v[0]), .r0_awaddr(awaddr_v[0]), .r0_awready(awready_v[0]),
        .r0_wdata(wdata_v[0]), .r0_wstrb(wstrb_v[0]), .r0_wvalid(wvalid_v[0]), .r0_wready(wready_v[0]),
        .r0_arvalid(arvalid_v[0]), .r0_araddr(araddr_v[0]), .r0_arready(arready_v[0]),
        .r0_rdata(rdata_v[0]), .r0_rvalid(rvalid_v[0]), .r0_rready(rready_v[0]),
        .r1_awvalid(awvalid_v[1]), .r1_awaddr(awaddr_v[1]), .r1_awready(awready_v[1]),
        .r1_wdata(wdata_v[1]), .r1_wstrb(wstrb_v[1]), .r1_wvalid(wvalid_v[1]), .r1_wready(wready_v[1]),
        .r1_arvalid(arvalid_v[1]), .r1_araddr(araddr_v[1]), .r1_arready(arready_v[1]),
        .r1_rdata(rdata_v[1]), .r1_rvalid(rvalid_v[1]), .r1_rready(rready_v[1]),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .grant(grant), .busy(busy)
    );

    typedef struct {
        logic          id;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [DW-1:0] srdata;
        logic [DW-1:0] exp_data;
    } vec_t;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic edge1;
        @(posedge CLK);
        #1;
    endtask

    task automatic smp;
        @(negedge CLK);
    endtask

    task automatic clear_inputs;
        awvalid_v = '0; wvalid_v = '0; arvalid_v = '0; rready_v = '0;
        awaddr_v = '0; araddr_v = '0; wdata_v = '0; wstrb_v = '0;
        s_awready = 1'b0; s_wready = 1'b0; s_arready = 1'b0;
        s_rvalid = 1'b0; s_rdata = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        RST_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
    endtask

    // One uncontended transaction with an immediately-ready slave
    task automatic run_txn(input vec_t v, input int n);
        logic [1:0] oh;
        logic       oid;
        oh  = v.id ? 2'b10 : 2'b01;
        oid = ~v.id;
        edge1();
        if (v.wr) begin
            awvalid_v[v.id] = 1'b1; awaddr_v[v.id] = v.addr;
            wvalid_v[v.id] = 1'b1; wdata_v[v.id] = v.data; wstrb_v[v.id] = v.strb;
        end else begin
            arvalid_v[v.id] = 1'b1; araddr_v[v.id] = v.addr; rready_v[v.id] = 1'b1;
        end
        smp();
        chk($sformatf("v%0d_busy_req", n), busy, 0);
        edge1(); smp();
        chk($sformatf("v%0d_busy_grant", n), busy, 1);
        chk($sformatf("v%0d_grant", n), grant, v.id);
        chk($sformatf("v%0d_awready", n), awready_v, v.wr ? oh : 2'b00);
        chk($sformatf("v%0d_arready", n), arready_v, v.wr ? 2'b00 : oh);
        chk($sformatf("v%0d_svalid_early", n), s_awvalid | s_arvalid, 0);
        if (v.wr) chk($sformatf("v%0d_s_awaddr", n), s_awaddr, v.addr);
        else      chk($sformatf("v%0d_s_araddr", n), s_araddr, v.addr);
        edge1();
        awvalid_v = '0; arvalid_v = '0;
        if (v.wr) begin
            s_awready = 1'b1; s_wready = 1'b1;
        end else begin
            s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = v.srdata;
        end
        smp();
        if (v.wr) begin
            chk($sformatf("v%0d_s_awvalid", n), s_awvalid, 1);
            chk($sformatf("v%0d_s_wvalid", n), s_wvalid, 1);
            chk($sformatf("v%0d_s_wdata", n), s_wdata, v.exp_data);
            chk($sformatf("v%0d_s_wstrb", n), s_wstrb, v.strb);
            chk($sformatf("v%0d_wready", n), wready_v, oh);
        end else begin
            chk($sformatf("v%0d_s_arvalid", n), s_arvalid, 1);
            chk($sformatf("v%0d_rvalid", n), rvalid_v, oh);
            chk($sformatf("v%0d_rdata", n), rdata_v[v.id], v.exp_data);
            chk($sformatf("v%0d_rdata_other", n), rdata_v[oid], 0);
            chk($sformatf("v%0d_s_rready", n), s_rready, 1);
        end
        edge1();
        clear_inputs();
        smp();
        chk($sformatf("v%0d_busy_done", n), busy, 0);
        chk($sformatf("v%0d_svalid_done", n), s_awvalid | s_arvalid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        logic [1:0] e;
        int t;

        vecs[0] = '{id: 1'b0, wr: 1'b1, addr: 12'h010, data: 32'h0000_005A, strb: 4'hF, srdata: 32'h0, exp_data: 32'h0000_005A};
        vecs[1] = '{id: 1'b1, wr: 1'b1, addr: 12'hFFC, data: 32'hDEAD_BEEF, strb: 4'h9, srdata: 32'h0, exp_data: 32'hDEAD_BEEF};
        vecs[2] = '{id: 1'b0, wr: 1'b0, addr: 12'h004, data: 32'h0, strb: 4'h0, srdata: 32'h1234_5678, exp_data: 32'h1234_5678};
        vecs[3] = '{id: 1'b1, wr: 1'b0, addr: 12'h800, data: 32'h0, strb: 4'h0, srdata: 32'hA5A5_0F0F, exp_data: 32'hA5A5_0F0F};
        vecs[4] = '{id: 1'b0, wr: 1'b1, addr: 12'h000, data: 32'hFFFF_FFFF, strb: 4'h0, srdata: 32'h0, exp_data: 32'hFFFF_FFFF};
        vecs[5] = '{id: 1'b1, wr: 1'b0, addr: 12'hFFF, data: 32'h0, strb: 4'h0, srdata: 32'h0, exp_data: 32'h0};

        // Reset state
        clear_inputs();
        RST_N = 1'b0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_s_valids", {s_awvalid, s_wvalid, s_arvalid, s_rready}, 0);
        chk("rst_s_awaddr", s_awaddr, 0);
        chk("rst_s_araddr", s_araddr, 0);
        chk("rst_s_wdata", s_wdata, 0);
        chk("rst_readies", {awready_v, wready_v, arready_v, rvalid_v}, 0);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;

        for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

        // Simultaneous writes after reset: r0 then r1
        do_reset();
        edge1();
        awvalid_v = 2'b11; awaddr_v[0] = 12'h020; awaddr_v[1] = 12'h024;
        wvalid_v = 2'b11; wdata_v[0] = 32'h11; wdata_v[1] = 32'h22; wstrb_v = '1;
        s_awready = 1'b1; s_wready = 1'b1;
        smp();
        chk("t2_busy0", busy, 0);
        edge1(); smp();
        chk("t2_grant_a", grant, 0);
        chk("t2_awready_a", awready_v, 2'b01);
        chk("t2_awaddr_a", s_awaddr, 12'h020);
        chk("t2_wready_a", wready_v, 2'b01);
        chk("t2_wdata_a", s_wdata, 32'h11);
        edge1();
        awvalid_v[0] = 1'b0; wvalid_v[0] = 1'b0;
        smp();
        chk("t2_s_awvalid_a", s_awvalid, 1);
        chk("t2_wready_gated", wready_v, 2'b00);
        edge1(); smp();
        chk("t2_idle_between", busy, 0);
        edge1(); smp();
        chk("t2_grant_b", grant, 1);
        chk("t2_awready_b", awready_v, 2'b10);
        chk("t2_awaddr_b", s_awaddr, 12'h024);
        chk("t2_wdata_b", s_wdata, 32'h22);
        edge1();
        awvalid_v[1] = 1'b0; wvalid_v[1] = 1'b0;
        smp();
        chk("t2_s_awvalid_b", s_awvalid, 1);
        edge1(); clear_inputs(); smp();
        chk("t2_busy_end", busy, 0);

        // Make prio=1, then r1 read vs r0 write in the same cycle
        run_txn(vecs[0], 10);
        edge1();
        awvalid_v[0] = 1'b1; awaddr_v[0] = 12'h030; wvalid_v[0] = 1'b1;
        wdata_v[0] = 32'h33; wstrb_v[0] = 4'hF;
        arvalid_v[1] = 1'b1; araddr_v[1] = 12'h040; rready_v[1] = 1'b1;
        s_wready = 1'b1;
        smp();
        edge1(); smp();
        chk("t3_grant_r1", grant, 1);
        chk("t3_arready", arready_v, 2'b10);
        chk("t3_awready_none", awready_v, 2'b00);
        chk("t3_r0_wready_hold", wready_v, 2'b00);
        edge1();
        arvalid_v[1] = 1'b0; s_arready = 1'b1;
        smp();
        chk("t3_s_arvalid", s_arvalid, 1);
        chk("t3_s_araddr", s_araddr, 12'h040);
        chk("t3_rvalid_none", rvalid_v, 2'b00);
        edge1();
        s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hCAFE_F00D;
        smp();
        chk("t3_busy_waitr", busy, 1);
        chk("t3_rvalid_r1", rvalid_v, 2'b10);
        chk("t3_rdata_r1", rdata_v[1], 32'hCAFE_F00D);
        chk("t3_rdata_r0", rdata_v[0], 0);
        chk("t3_r0_ready_hold", {awready_v[0], wready_v[0], arready_v[0]}, 0);
        edge1();
        s_rvalid = 1'b0; s_rdata = '0; rready_v[1] = 1'b0; s_wready = 1'b0;
        smp();
        chk("t3_busy_after_read", busy, 0);
        edge1(); smp();
        chk("t3_grant_r0", grant, 0);
        chk("t3_awready_r0", awready_v, 2'b01);
        chk("t3_awaddr_r0", s_awaddr, 12'h030);
        edge1();
        awvalid_v[0] = 1'b0; s_awready = 1'b1;
        smp();
        chk("t3_s_awvalid", s_awvalid, 1);
        chk("t3_wready_wait", wready_v, 2'b00);
        edge1();
        s_awready = 1'b0; s_wready = 1'b1;
        smp();
        chk("t3_s_awvalid_dropped", s_awvalid, 0);
        chk("t3_busy_data_late", busy, 1);
        chk("t3_wready_late", wready_v, 2'b01);
        chk("t3_wdata_late", s_wdata, 32'h33);
        edge1(); clear_inputs(); smp();
        chk("t3_busy_end", busy, 0);

        // Address and data accepted in the same cycle as r0_wvalid rises
        edge1();
        awvalid_v[0] = 1'b1; awaddr_v[0] = 12'h044;
        smp();
        edge1(); smp();
        chk("t4_awready", awready_v, 2'b01);
        chk("t4_s_wvalid_early", s_wvalid, 0);
        edge1();
        awvalid_v[0] = 1'b0; wvalid_v[0] = 1'b1; wdata_v[0] = 32'h44; wstrb_v[0] = 4'h3;
        s_awready = 1'b1; s_wready = 1'b1;
        smp();
        chk("t4_s_wvalid", s_wvalid, 1);
        chk("t4_wready", wready_v, 2'b01);
        chk("t4_s_wdata", s_wdata, 32'h44);
        edge1(); smp();
        chk("t4_idle_next", busy, 0);
        chk("t4_s_awvalid_off", s_awvalid, 0);
        chk("t4_w_closed", {s_wvalid, wready_v}, 0);
        edge1(); clear_inputs();

        // Asynchronous reset during READ with s_rvalid high
        edge1();
        arvalid_v[1] = 1'b1; araddr_v[1] = 12'h0AB; rready_v[1] = 1'b1;
        smp();
        edge1(); smp();
        chk("t5_arready", arready_v, 2'b10);
        edge1();
        arvalid_v[1] = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h77;
        smp();
        chk("t5_rvalid_pre", rvalid_v, 2'b10);
        #2 RST_N = 1'b0;
        #1;
        chk("t5_busy_rst", busy, 0);
        chk("t5_grant_rst", grant, 0);
        chk("t5_s_ar_rst", {s_arvalid, s_rready}, 0);
        chk("t5_s_araddr_rst", s_araddr, 0);
        chk("t5_rvalid_rst", rvalid_v, 2'b00);
        chk("t5_rdata_rst", rdata_v[1], 0);
        clear_inputs();
        @(posedge CLK);
        #1 RST_N = 1'b1;
        edge1();
        awvalid_v = 2'b11; awaddr_v[0] = 12'h050; awaddr_v[1] = 12'h054;
        wvalid_v = 2'b11; s_awready = 1'b1; s_wready = 1'b1;
        smp();
        chk("t5_idle_after", busy, 0);
        edge1(); smp();
        chk("t5_prio0_grant", grant, 0);
        chk("t5_prio0_awready", awready_v, 2'b01);

        // Continuous contention: round-robin alternates, fixed priority keeps r0
        do_reset();
        awvalid_v = 2'b11; awaddr_v[0] = 12'h060; awaddr_v[1] = 12'h064;
        wvalid_v = 2'b11; wdata_v[0] = 32'h66; wdata_v[1] = 32'h67; wstrb_v = '1;
        s_awready = 1'b1; s_wready = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef IPGEN_ARB_FIXED_PRIO_EN
            e = 2'b01;
`else
            e = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
            t = 0;
            do begin
                edge1(); smp(); t++;
            end while (awready_v == 2'b00 && t < 10);
            chk($sformatf("t6_winner_%0d", k), awready_v, e);
        end
        edge1(); clear_inputs();
        repeat (4) edge1();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
